// File: rtl/display7seg_pkg.sv
// Shared types and segment constants for the multiplexed seven-segment driver.
// Segment vectors are ordered a..g with index 0 = a, active-high.
package display7seg_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/display7seg_mux_hex7seg.sv
// Combinational hex nibble to seven-segment decoder (a..g, active-high).
module hex7seg
    import display7seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/display7seg_mux.sv
// Time-multiplexed seven-segment display driver with registered outputs.
// Optional leading-zero blanking is enabled by defining DISPLAY7SEG_LZB_EN.
module display7seg_mux
    import display7seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] entrada,
    input  logic [NUM_DIGITS-1:0]   ponto,
    output logic [0:6]              saida,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodo,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(PRESCALE);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] sh_ent;
    logic [NUM_DIGITS-1:0]   sh_pt;
    logic                    tick;
    logic                    scan_wrap;
    logic [3:0]              nib;
    logic                    dp_sel;
    logic [NUM_DIGITS-1:0]   anodo_sel;
    seg_t                    seg_dec;
    seg_t                    seg_sel;

    assign tick = (cnt == CNT_W'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // load is a single-cycle strobe with no back-pressure: the shadows are
    // overwritten on every edge it is high and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_ent <= '0;
            sh_pt  <= '0;
        end else if (load) begin
            sh_ent <= entrada;
            sh_pt  <= ponto;
        end
    end

    always_comb begin
        nib       = 4'h0;
        dp_sel    = 1'b0;
        anodo_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib          = sh_ent[4*i +: 4];
                dp_sel       = sh_pt[i];
                anodo_sel[i] = 1'b1;
            end
        end
    end

    hex7seg u_hex7seg (
        .nibble (nib),
        .seg    (seg_dec)
    );

`ifdef DISPLAY7SEG_LZB_EN
    logic blank;

    // A digit is a leading zero when it and every higher digit are zero;
    // digit 0 always shows so a zero value still reads "0".
    always_comb begin
        blank = (idx != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) >= idx) && (sh_ent[4*i +: 4] != 4'h0))
                blank = 1'b0;
        end
    end

    assign seg_sel = blank ? SEG_BLANK : seg_dec;
`else
    assign seg_sel = seg_dec;
`endif

    // scan_wrap marks the edge where idx returned to 0, so frame_done lines
    // up with the registered anodo switching to digit 0 one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_wrap  <= 1'b0;
            saida      <= SEG_BLANK;
            dp         <= 1'b0;
            anodo      <= '0;
            frame_done <= 1'b0;
        end else begin
            scan_wrap  <= tick && (idx == IDX_W'(NUM_DIGITS - 1));
            saida      <= seg_sel;
            dp         <= dp_sel;
            anodo      <= anodo_sel;
            frame_done <= scan_wrap;
        end
    end

endmodule

// File: tb/tb_display7seg_mux.sv
// Randomized scoreboard bench for display7seg_mux (NUM_DIGITS=4, PRESCALE=4).
// Define DISPLAY7SEG_LZB_EN for both bench and RTL to check blanking.
module tb_display7seg_mux;

    localparam int N = 4;
    localparam int P = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        load    = 1'b0;
    logic [15:0] entrada = '0;
    logic [3:0]  ponto   = '0;
    logic [0:6]  saida;
    logic        dp;
    logic [3:0]  anodo;
    logic        frame_done;

    display7seg_mux #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .entrada    (entrada),
        .ponto      (ponto),
        .saida      (saida),
        .dp         (dp),
        .anodo      (anodo),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          tests   = 0;
    int          fails   = 0;
    logic [12:0] exp_q[$];
    logic        driving = 1'b0;
    logic        done    = 1'b0;

    // Reference state: edges seen since reset release plus latest loaded values.
    int          m_cnt = 0;
    logic [15:0] m_ent = '0;
    logic [3:0]  m_pt  = '0;

    logic [6:0] dec_tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Expected {anodo, dp, saida, frame_done} one edge after state m.
    function automatic logic [12:0] model_out(input int m, input logic [15:0] ent,
                                              input logic [3:0] pt);
        int         d;
        logic [3:0] nib;
        logic [6:0] seg;
        logic       fd;
        d   = (m / P) % N;
        nib = ent[4*d +: 4];
        seg = dec_tbl[nib];
`ifdef DISPLAY7SEG_LZB_EN
        if (d != 0 && (ent >> (4*d)) == 16'h0)
            seg = 7'b0000000;
`endif
        fd = (m > 0) && (m % (P*N) == 0);
        return {4'(1 << d), pt[d], seg, fd};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: anodo/dp/saida/fd got %b/%b/%b/%b expected %b/%b/%b/%b",
                     name, $time, act[12:9], act[8], act[7:1], act[0],
                     exp[12:9], exp[8], exp[7:1], exp[0]);
        end
    endtask

    task automatic step(input logic rst, input logic ld, input logic [15:0] ent,
                        input logic [3:0] pt);
        logic was_running;
        @(negedge clk);
        if (rst) exp_q.push_back('0);
        else     exp_q.push_back(model_out(m_cnt, m_ent, m_pt));
        driving     = 1'b1;
        was_running = rst_n;
        rst_n   = ~rst;
        load    = ld;
        entrada = ent;
        ponto   = pt;
        if (rst) begin
            if (was_running) begin
                #1 check("async_reset", {anodo, dp, saida, frame_done}, 13'h0);
            end
            m_cnt = 0;
            m_ent = '0;
            m_pt  = '0;
        end else begin
            if (ld) begin
                m_ent = ent;
                m_pt  = pt;
            end
            m_cnt++;
        end
    endtask

    task automatic idle_steps(input int n);
        repeat (n) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    // Monitor: one expectation is due after every clock edge once driving starts.
    initial begin
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0)
                check("scan", {anodo, dp, saida, frame_done}, exp_q.pop_front());
            else if (driving && !done) begin
                tests++;
                fails++;
                $display("FAIL scan @%0t: no expectation queued", $time);
            end
        end
    end

    initial begin
        logic [15:0] ent;

        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0);
        idle_steps(40);

        step(1'b0, 1'b1, 16'h1A3F, 4'b0100);
        idle_steps(24);

        while ((m_cnt + 1) % P != 0) idle_steps(1);
        step(1'b0, 1'b1, 16'hC5E9, 4'b1001);
        idle_steps(20);

        repeat (300) begin
            ent = 16'($urandom);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 2) == 0) ent[4*k +: 4] = 4'h0;
            step(1'b0, ($urandom_range(0, 3) == 0), ent, 4'($urandom));
        end

        while (((m_cnt - 1) / P) % N != 2 || (m_cnt % P) != 2) idle_steps(1);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 16'hFFFF, 4'hF);
        idle_steps(24);

        step(1'b0, 1'b1, 16'h0070, 4'b0101);
        idle_steps(20);
        step(1'b0, 1'b1, 16'h0000, 4'b0000);
        idle_steps(20);

        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
